// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM that sequences fetch/decode/execute/
// memory/writeback and drives every datapath select, write enable and ALU control.
module mc_control_fsm #(
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             memwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;

    state_t     w_next;
    logic       w_ready;
    logic       w_retire;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic [2:0] w_funct_alu;

    assign w_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_comb begin
        case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_alu = ALU_ADD;
        endcase
    end

    // Moore outputs; illegal also looks at op since it flags the DECODE cycle itself
    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        case (r_state)
            FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                    OP_BNE, OP_ADDI, OP_J: illegal = 1'b0;
                    default:               illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = zero;
            end
            BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = ~zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: w_regwrite = 1'b1;
            JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset so nothing commits while reset is held
    assign irwrite  = reset & w_irwrite;
    assign pcen     = reset & (w_pcwrite | w_branch);
    assign regwrite = reset & w_regwrite;
    assign memwrite = reset & w_memwrite;
    assign state    = r_state;
    assign retired  = r_retired;

    always_comb begin
        w_next   = FETCH;
        w_retire = 1'b0;
        case (r_state)
            FETCH:  w_next = w_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_BNE:       w_next = BNEEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = w_ready ? MEMWB : MEMRD;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX: begin
                w_next   = FETCH;
                w_retire = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule
